// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, opcode/funct constants, datapath select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_WB_R      = 4'd8,
        S_WB_I      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_SRA = 6'd3;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [2:0] SRCB_REG     = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_IMM     = 3'b010;
    localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;
    localparam logic [2:0] SRCB_ZERO    = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control the FSM drives, grouped so reset can blank them at once.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       branch_ne;
    } ctrl_t;

    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of consecutive not-ready cycles in one memory wait;
// flags a timeout once the limit is reached and memory is still not ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // A zero limit means no timeout at all.
    assign timeout = (MEM_TIMEOUT > 0) && count && (count_reg == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with branch/jump execution, req/ready memory
// handshake with a bounded wait, and a sticky trap for bad opcodes or timeouts.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT    = 15,
    parameter int SUPPORT_BRANCH = 1,
    parameter int SUPPORT_JUMP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op_code,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       branch_ne,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);

    localparam logic BRANCH_EN = (SUPPORT_BRANCH != 0);
    localparam logic JUMP_EN   = (SUPPORT_JUMP != 0);

    state_t state_reg, state_next;
    ctrl_t  ctrl_c, ctrl_o;
    logic   illegal_reg, timeout_reg;
    logic   set_illegal, set_timeout;
    logic   wait_active, timer_clear, timer_count, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (set_illegal) illegal_reg <= 1'b1;
            if (set_timeout) timeout_reg <= 1'b1;
        end
    end

    // Any state change restarts the wait count, so each wait state starts from zero.
    assign timer_clear = (state_next != state_reg);
    assign timer_count = wait_active && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .count   (timer_count),
        .timeout (timeout)
    );

    always_comb begin
        ctrl_c      = '0;
        state_next  = state_reg;
        wait_active = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_reg)
            S_FETCH: begin
                wait_active       = 1'b1;
                ctrl_c.mem_req    = 1'b1;
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.alu_op     = ALUOP_ADD;
                ctrl_c.pc_source  = PCSRC_ALU;
                ctrl_c.ir_write   = mem_ready;
                ctrl_c.pc_write   = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_IMM_SH2;
                ctrl_c.alu_op    = ALUOP_ADD;
                if (Op_code == OP_RTYPE) begin
                    state_next = S_EXEC_R;
                end else if (is_itype(Op_code)) begin
                    state_next = S_EXEC_I;
                end else if ((Op_code == OP_LW) || (Op_code == OP_SW)) begin
                    state_next = S_MEM_ADDR;
                end else if (BRANCH_EN && ((Op_code == OP_BEQ) || (Op_code == OP_BNE))) begin
                    state_next = S_BRANCH;
                end else if (JUMP_EN && (Op_code == OP_J)) begin
                    state_next = S_JUMP;
                end else begin
                    state_next  = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_EXEC_R: begin
                ctrl_c.alu_op = ALUOP_FUNCT;
                if (is_shift(Funct)) begin
                    ctrl_c.alu_src_a = SRCA_SHAMT;
                    ctrl_c.alu_src_b = SRCB_ZERO;
                end else begin
                    ctrl_c.alu_src_a = SRCA_REG;
                    ctrl_c.alu_src_b = SRCB_REG;
                end
                state_next = S_WB_R;
            end
            S_EXEC_I: begin
                ctrl_c.alu_src_a = SRCA_REG;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ITYPE;
                state_next       = S_WB_I;
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = SRCA_REG;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                state_next       = (Op_code == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                wait_active    = 1'b1;
                ctrl_c.mem_req = 1'b1;
                ctrl_c.i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_MEM_WRITE: begin
                wait_active      = 1'b1;
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                ctrl_c.mem_write = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_MEM_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.memto_reg = 1'b1;
                ctrl_c.reg_dst   = 1'b0;
                state_next       = S_FETCH;
            end
            S_WB_R: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                state_next       = S_FETCH;
            end
            S_WB_I: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b0;
                state_next       = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = SRCA_REG;
                ctrl_c.alu_src_b     = SRCB_REG;
                ctrl_c.alu_op        = ALUOP_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
                ctrl_c.branch_ne     = (Op_code == OP_BNE);
                state_next           = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                state_next       = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset blanks every control combinationally, even mid-access.
    assign ctrl_o = rst_n ? ctrl_c : '0;

    assign mem_req     = ctrl_o.mem_req;
    assign MemWrite    = ctrl_o.mem_write;
    assign IRWrite     = ctrl_o.ir_write;
    assign MemtoReg    = ctrl_o.memto_reg;
    assign RegDst      = ctrl_o.reg_dst;
    assign RegWrite    = ctrl_o.reg_write;
    assign PCWriteCond = ctrl_o.pc_write_cond;
    assign PCWrite     = ctrl_o.pc_write;
    assign IorD        = ctrl_o.i_or_d;
    assign ALUSrcA     = ctrl_o.alu_src_a;
    assign ALUSrcB     = ctrl_o.alu_src_b;
    assign ALUOp       = ctrl_o.alu_op;
    assign PCSource    = ctrl_o.pc_source;
    assign branch_ne   = ctrl_o.branch_ne;
    assign illegal_op  = illegal_reg;
    assign mem_timeout = timeout_reg;
    assign state_dbg   = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench: a per-instruction cycle plan built from the
// control rules is compared cycle by cycle against two differently configured DUTs.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       req, we, irw, m2r, rdst, rw, pcc, pcw, iord;
        logic [1:0] a;
        logic [2:0] b;
        logic [1:0] aop;
        logic [1:0] pcs;
        logic       bne, il, mt;
    } ov_t;

    typedef struct {
        state_t st;
        logic   rdy;
        ov_t    o;
    } step_t;

    logic       clk;
    logic       rst_n0, rst_n1;
    logic [5:0] op, funct;
    logic       mem_ready;
    logic       sel;

    logic       mem_req0, MemWrite0, IRWrite0, MemtoReg0, RegDst0, RegWrite0;
    logic       PCWriteCond0, PCWrite0, IorD0, branch_ne0, illegal_op0, mem_timeout0;
    logic [1:0] ALUSrcA0, ALUOp0, PCSource0;
    logic [2:0] ALUSrcB0;
    logic [3:0] state_dbg0;
    logic       mem_req1, MemWrite1, IRWrite1, MemtoReg1, RegDst1, RegWrite1;
    logic       PCWriteCond1, PCWrite1, IorD1, branch_ne1, illegal_op1, mem_timeout1;
    logic [1:0] ALUSrcA1, ALUOp1, PCSource1;
    logic [2:0] ALUSrcB1;
    logic [3:0] state_dbg1;

    ov_t        obs0, obs1, obs;
    logic [3:0] obs_st;

    int    total = 0;
    int    bad   = 0;
    int    txn   = 0;
    step_t plan[$];

    logic [5:0] op_tab [11] = '{6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
    logic [5:0] fn_tab [8]  = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .SUPPORT_BRANCH(1), .SUPPORT_JUMP(1)) dut0 (
        .clk(clk), .rst_n(rst_n0), .Op_code(op), .Funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req0), .MemWrite(MemWrite0), .IRWrite(IRWrite0), .MemtoReg(MemtoReg0),
        .RegDst(RegDst0), .RegWrite(RegWrite0), .PCWriteCond(PCWriteCond0), .PCWrite(PCWrite0),
        .IorD(IorD0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0),
        .PCSource(PCSource0), .branch_ne(branch_ne0), .illegal_op(illegal_op0),
        .mem_timeout(mem_timeout0), .state_dbg(state_dbg0)
    );

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .SUPPORT_BRANCH(0), .SUPPORT_JUMP(0)) dut1 (
        .clk(clk), .rst_n(rst_n1), .Op_code(op), .Funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req1), .MemWrite(MemWrite1), .IRWrite(IRWrite1), .MemtoReg(MemtoReg1),
        .RegDst(RegDst1), .RegWrite(RegWrite1), .PCWriteCond(PCWriteCond1), .PCWrite(PCWrite1),
        .IorD(IorD1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ALUOp(ALUOp1),
        .PCSource(PCSource1), .branch_ne(branch_ne1), .illegal_op(illegal_op1),
        .mem_timeout(mem_timeout1), .state_dbg(state_dbg1)
    );

    assign obs0 = {mem_req0, MemWrite0, IRWrite0, MemtoReg0, RegDst0, RegWrite0, PCWriteCond0,
                   PCWrite0, IorD0, ALUSrcA0, ALUSrcB0, ALUOp0, PCSource0, branch_ne0,
                   illegal_op0, mem_timeout0};
    assign obs1 = {mem_req1, MemWrite1, IRWrite1, MemtoReg1, RegDst1, RegWrite1, PCWriteCond1,
                   PCWrite1, IorD1, ALUSrcA1, ALUSrcB1, ALUOp1, PCSource1, branch_ne1,
                   illegal_op1, mem_timeout1};

    always_comb begin
        obs    = sel ? obs1 : obs0;
        obs_st = sel ? state_dbg1 : state_dbg0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input state_t s, input logic r, input ov_t o);
        step_t x;
        x.st  = s;
        x.rdy = r;
        x.o   = o;
        plan.push_back(x);
    endtask

    task automatic add_trap(input int n, input logic il, input logic mt);
        ov_t o;
        o    = '0;
        o.il = il;
        o.mt = mt;
        for (int i = 0; i < n; i++) push(S_TRAP, 1'($urandom_range(0, 1)), o);
    endtask

    // A wait of n not-ready cycles; beyond the limit it ends in the trap.
    task automatic add_wait(input state_t s, input int n, input int lim, input ov_t ow,
                            input ov_t od, output bit trapped);
        trapped = 0;
        if (lim != 0 && n > lim) begin
            for (int i = 0; i <= lim; i++) push(s, 1'b0, ow);
            trapped = 1;
        end else begin
            for (int i = 0; i < n; i++) push(s, 1'b0, ow);
            push(s, 1'b1, od);
        end
    endtask

    task automatic build(input logic [5:0] o_op, input logic [5:0] o_fn, input int fw,
                         input int mw, input int lim, input bit br, input bit jp, input int ntrap);
        ov_t o, od;
        bit  tr;
        bit  shift;
        plan.delete();
        o = '0; o.req = 1; o.b = 3'b001;
        od = o; od.irw = 1; od.pcw = 1;
        add_wait(S_FETCH, fw, lim, o, od, tr);
        if (tr) begin
            add_trap(ntrap, 1'b0, 1'b1);
            return;
        end
        o = '0; o.b = 3'b011;
        push(S_DECODE, 1'($urandom_range(0, 1)), o);
        if (o_op == 6'd0) begin
            shift = (o_fn == 6'd0) || (o_fn == 6'd2) || (o_fn == 6'd3);
            o = '0; o.aop = 2'b10;
            o.a = shift ? 2'b10 : 2'b01;
            o.b = shift ? 3'b100 : 3'b000;
            push(S_EXEC_R, 1'($urandom_range(0, 1)), o);
            o = '0; o.rw = 1; o.rdst = 1;
            push(S_WB_R, 1'($urandom_range(0, 1)), o);
        end else if (o_op == 8 || o_op == 10 || o_op == 12 || o_op == 13 || o_op == 14) begin
            o = '0; o.a = 2'b01; o.b = 3'b010; o.aop = 2'b11;
            push(S_EXEC_I, 1'($urandom_range(0, 1)), o);
            o = '0; o.rw = 1;
            push(S_WB_I, 1'($urandom_range(0, 1)), o);
        end else if (o_op == 35 || o_op == 43) begin
            o = '0; o.a = 2'b01; o.b = 3'b010;
            push(S_MEM_ADDR, 1'($urandom_range(0, 1)), o);
            o = '0; o.req = 1; o.iord = 1; o.we = (o_op == 43);
            add_wait((o_op == 43) ? S_MEM_WRITE : S_MEM_READ, mw, lim, o, o, tr);
            if (tr) begin
                add_trap(ntrap, 1'b0, 1'b1);
            end else if (o_op == 35) begin
                o = '0; o.rw = 1; o.m2r = 1;
                push(S_MEM_WB, 1'($urandom_range(0, 1)), o);
            end
        end else if ((o_op == 4 || o_op == 5) && br) begin
            o = '0; o.a = 2'b01; o.aop = 2'b01; o.pcc = 1; o.pcs = 2'b01; o.bne = (o_op == 5);
            push(S_BRANCH, 1'($urandom_range(0, 1)), o);
        end else if (o_op == 2 && jp) begin
            o = '0; o.pcw = 1; o.pcs = 2'b10;
            push(S_JUMP, 1'($urandom_range(0, 1)), o);
        end else begin
            add_trap(ntrap, 1'b1, 1'b0);
        end
    endtask

    // Entered and left at a falling edge; each step covers one clock cycle.
    task automatic run_plan(input int n_max);
        for (int i = 0; i < plan.size() && i < n_max; i++) begin
            mem_ready = plan[i].rdy;
            #1;
            check_eq($sformatf("t%0d_state[%0d]", txn, i), 32'(obs_st), 32'(plan[i].st));
            check_eq($sformatf("t%0d_outs[%0d]", txn, i), 32'(obs), 32'(plan[i].o));
            @(negedge clk);
        end
    endtask

    task automatic do_txn(input logic [5:0] o_op, input logic [5:0] o_fn, input int fw,
                          input int mw, input int ntrap);
        op    = o_op;
        funct = o_fn;
        if (sel) build(o_op, o_fn, fw, mw, 4, 1'b0, 1'b0, ntrap);
        else     build(o_op, o_fn, fw, mw, 15, 1'b1, 1'b1, ntrap);
        run_plan(plan.size());
        $display("txn %0d dut%0d op=%0d funct=%0d fw=%0d mw=%0d cycles=%0d",
                 txn, sel, o_op, o_fn, fw, mw, plan.size());
        txn++;
    endtask

    task automatic reset_pulse();
        if (sel) rst_n1 = 1'b0; else rst_n0 = 1'b0;
        #1;
        check_eq($sformatf("rst%0d_outs", txn), 32'(obs), 32'(0));
        check_eq($sformatf("rst%0d_state", txn), 32'(obs_st), 32'(S_FETCH));
        @(negedge clk);
        if (sel) rst_n1 = 1'b1; else rst_n0 = 1'b1;
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0; sel = 1'b0;
        op = '0; funct = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_eq("reset_outs0", 32'(obs0), 32'(0));
        check_eq("reset_state0", 32'(state_dbg0), 32'(S_FETCH));
        check_eq("reset_outs1", 32'(obs1), 32'(0));
        @(negedge clk);
        rst_n0 = 1'b1;

        do_txn(6'd0, 6'd32, 0, 0, 0);
        do_txn(6'd35, 6'd0, 0, 3, 0);
        do_txn(6'd5, 6'd0, 1, 0, 0);
        do_txn(6'd4, 6'd0, 0, 0, 0);
        do_txn(6'd0, 6'd0, 0, 0, 0);
        do_txn(6'd0, 6'd34, 2, 0, 0);
        do_txn(6'd43, 6'd0, 0, 2, 0);
        do_txn(6'd2, 6'd0, 0, 0, 0);
        do_txn(6'd8, 6'd0, 15, 0, 0);
        for (int k = 0; k < 40; k++) begin
            do_txn(op_tab[$urandom_range(0, 10)], fn_tab[$urandom_range(0, 7)],
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        // Reset in the middle of a store wait.
        op = 6'd43; funct = 6'd0;
        build(6'd43, 6'd0, 0, 3, 15, 1'b1, 1'b1, 0);
        run_plan(4);
        mem_ready = 1'b0;
        #1;
        check_eq("sw_wait_memwrite", 32'(MemWrite0), 32'(1));
        rst_n0 = 1'b0;
        #1;
        check_eq("sw_rst_memwrite", 32'(MemWrite0), 32'(0));
        check_eq("sw_rst_memreq", 32'(mem_req0), 32'(0));
        check_eq("sw_rst_state", 32'(state_dbg0), 32'(S_FETCH));
        @(negedge clk);
        rst_n0 = 1'b1;

        do_txn(6'd63, 6'd0, 0, 0, 5);
        reset_pulse();
        do_txn(6'd0, 6'd36, 0, 0, 0);

        sel    = 1'b1;
        rst_n1 = 1'b1;
        do_txn(6'd0, 6'd32, 0, 0, 0);
        do_txn(6'd35, 6'd0, 4, 4, 0);
        do_txn(6'd43, 6'd0, 1, 4, 0);
        do_txn(6'd5, 6'd0, 0, 0, 3);
        reset_pulse();
        do_txn(6'd4, 6'd0, 0, 0, 3);
        reset_pulse();
        do_txn(6'd2, 6'd0, 0, 0, 3);
        reset_pulse();
        do_txn(6'd0, 6'd32, 10, 0, 20);
        reset_pulse();
        do_txn(6'd35, 6'd0, 0, 7, 4);
        reset_pulse();
        for (int k = 0; k < 10; k++) begin
            do_txn(op_tab[$urandom_range(0, 7)], fn_tab[$urandom_range(0, 7)],
                   $urandom_range(0, 4), $urandom_range(0, 4), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
